// File: rtl/nn_pkg.sv
// Shared NN stream definitions: transmitter states, default sizes and a
// width helper used by the sender and the layer blocks.
package nn_pkg;

   localparam int NN_N     = 8;
   localparam int NN_T     = 16;
   localparam int NN_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } tx_state_t;

   // Bits needed to encode 0..value-1, never less than one bit.
   function automatic int clog2_w(input int value);
      return (value < 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/nn_dp_mem.sv
// Simple dual-port word store: one write port and one registered read port.
// No reset on the array so it maps onto block RAM.
module nn_dp_mem
   import nn_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SIZE  = 32,
   localparam int AW   = clog2_w(SIZE)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [SIZE];
   logic [WIDTH-1:0] rdata_q;

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Registered read port; output holds until the next read.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/nn_vec_sender.sv
// nn_vec_sender: collects host words into N-word vectors and streams only
// fully written vectors to a layer input at up to one word per cycle.
module nn_vec_sender
   import nn_pkg::*;
#(
   parameter int N     = NN_N,
   parameter int T     = NN_T,
   parameter int DEPTH = NN_DEPTH,
   localparam int SIZE = N * DEPTH,
   localparam int AW   = clog2_w(SIZE),
   localparam int UW   = clog2_w(SIZE + 1),
   localparam int VW   = clog2_w(DEPTH + 1),
   localparam int CW   = clog2_w(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [T-1:0]  wr_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [T-1:0]  data_out,
   output logic          m_last,
   output logic [VW-1:0] vec_avail
);

   // clear request: reset (active low) or flush, both act at the clock edge
   logic          clr;

   // write side
   logic          en_q;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic [UW-1:0] words_used_q, words_used_d;
   logic          wr_fire;
   logic          commit;

   // read issue side
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] rd_idx_q, rd_idx_d;
   logic [UW-1:0] rd_left_q, rd_left_d;
   logic          rd_issue;
   logic          rvld_q, rvld_d;
   logic          rlast_q, rlast_d;
   logic [T-1:0]  rd_data;

   // output register and skid
   logic          m_valid_q, m_valid_d;
   logic [T-1:0]  data_out_q, data_out_d;
   logic          m_last_q, m_last_d;
   logic          skid_vld_q, skid_vld_d;
   logic [T-1:0]  skid_data_q, skid_data_d;
   logic          skid_last_q, skid_last_d;
   logic          out_fire;
   logic          last_fire;

   // vector bookkeeping and transmit FSM
   logic [VW-1:0] vec_avail_q, vec_avail_d;
   tx_state_t     state_q, state_d;

   assign clr       = !reset || flush;
   assign wr_ready  = en_q && (words_used_q < UW'(SIZE));
   assign wr_fire   = wr_valid && wr_ready && !clr;
   assign commit    = wr_fire && (wcnt_q == CW'(N - 1));
   assign out_fire  = m_valid_q && m_ready;
   assign last_fire = out_fire && m_last_q;

   assign m_valid   = m_valid_q;
   assign data_out  = data_out_q;
   assign m_last    = m_last_q;
   assign vec_avail = vec_avail_q;

   nn_dp_mem #(
      .WIDTH (T),
      .SIZE  (SIZE)
   ) u_mem (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (wptr_q),
      .wdata (wr_data),
      .re    (rd_issue),
      .raddr (rptr_q),
      .rdata (rd_data)
   );

   // Write pointer wraps at SIZE-1; word counter marks the vector boundary.
   always_comb begin
      wptr_d = wptr_q;
      wcnt_d = wcnt_q;
      if (wr_fire) begin
         wptr_d = (wptr_q == AW'(SIZE - 1)) ? '0 : wptr_q + AW'(1);
         wcnt_d = (wcnt_q == CW'(N - 1)) ? '0 : wcnt_q + CW'(1);
      end
   end

   // Occupancy: a slot is taken on write and freed at the edge its word leaves.
   always_comb begin
      words_used_d = words_used_q;
      if (wr_fire && !out_fire) begin
         words_used_d = words_used_q + UW'(1);
      end else if (!wr_fire && out_fire) begin
         words_used_d = words_used_q - UW'(1);
      end
   end

   // Output stage: the presented word moves on only after a transfer, refilled
   // from the skid first, then from the word arriving out of the memory.
   always_comb begin
      m_valid_d   = m_valid_q;
      data_out_d  = data_out_q;
      m_last_d    = m_last_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;
      if (!m_valid_q || out_fire) begin
         if (skid_vld_q) begin
            m_valid_d   = 1'b1;
            data_out_d  = skid_data_q;
            m_last_d    = skid_last_q;
            skid_vld_d  = rvld_q;
            skid_data_d = rd_data;
            skid_last_d = rlast_q;
         end else if (rvld_q) begin
            m_valid_d  = 1'b1;
            data_out_d = rd_data;
            m_last_d   = rlast_q;
         end else begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end
      end else if (rvld_q) begin
         skid_vld_d  = 1'b1;
         skid_data_d = rd_data;
         skid_last_d = rlast_q;
      end
   end

   // Prefetch: read the next committed word whenever the output stage and skid
   // will still have a free place for it when it returns from the memory.
   always_comb begin
      rd_issue = (rd_left_q != '0) && !(m_valid_d && skid_vld_d);
      rptr_d   = rptr_q;
      rd_idx_d = rd_idx_q;
      rvld_d   = rd_issue;
      rlast_d  = rd_issue && (rd_idx_q == CW'(N - 1));
      if (rd_issue) begin
         rptr_d   = (rptr_q == AW'(SIZE - 1)) ? '0 : rptr_q + AW'(1);
         rd_idx_d = (rd_idx_q == CW'(N - 1)) ? '0 : rd_idx_q + CW'(1);
      end
   end

   // Committed-but-unread words and committed-but-unsent vectors.
   always_comb begin
      rd_left_d = rd_left_q + (commit ? UW'(N) : UW'(0)) - (rd_issue ? UW'(1) : UW'(0));
      vec_avail_d = vec_avail_q;
      if (commit && !last_fire) begin
         vec_avail_d = vec_avail_q + VW'(1);
      end else if (!commit && last_fire) begin
         vec_avail_d = vec_avail_q - VW'(1);
      end
   end

   // Vector-level phase: wait for a vector, wait for its first read, then send
   // until no committed vector remains after a final word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (vec_avail_q != '0) state_d = FETCH;
         FETCH:   state_d = SEND;
         SEND:    if (last_fire && (vec_avail_d == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transmit FSM state register.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Pointers, counters, output register and skid; flush clears like reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         en_q         <= 1'b0;
         wptr_q       <= '0;
         wcnt_q       <= '0;
         words_used_q <= '0;
         rptr_q       <= '0;
         rd_idx_q     <= '0;
         rd_left_q    <= '0;
         rvld_q       <= 1'b0;
         rlast_q      <= 1'b0;
         m_valid_q    <= 1'b0;
         data_out_q   <= '0;
         m_last_q     <= 1'b0;
         skid_vld_q   <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
         vec_avail_q  <= '0;
      end else begin
         en_q         <= 1'b1;
         wptr_q       <= wptr_d;
         wcnt_q       <= wcnt_d;
         words_used_q <= words_used_d;
         rptr_q       <= rptr_d;
         rd_idx_q     <= rd_idx_d;
         rd_left_q    <= rd_left_d;
         rvld_q       <= rvld_d;
         rlast_q      <= rlast_d;
         m_valid_q    <= m_valid_d;
         data_out_q   <= data_out_d;
         m_last_q     <= m_last_d;
         skid_vld_q   <= skid_vld_d;
         skid_data_q  <= skid_data_d;
         skid_last_q  <= skid_last_d;
         vec_avail_q  <= vec_avail_d;
      end
   end

   // Structural invariants of the buffer and output pipeline.
   a_skid_behind_out : assert property (@(posedge clk) disable iff (!reset)
      skid_vld_q |-> m_valid_q);
   a_used_bound : assert property (@(posedge clk) disable iff (!reset)
      words_used_q <= UW'(SIZE));
   a_vec_bound : assert property (@(posedge clk) disable iff (!reset)
      vec_avail_q <= VW'(DEPTH));

endmodule

// File: tb/tb_nn_vec_sender.sv
// Self-checking bench for nn_vec_sender: a queue-based model of committed
// words is compared against the DUT every cycle, plus directed scenarios.
module tb_nn_vec_sender;

   localparam int N     = 8;
   localparam int T     = 16;
   localparam int DEPTH = 4;
   localparam int SIZE  = N * DEPTH;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         flush = 1'b0;
   logic         wr_valid = 1'b0;
   logic [T-1:0] wr_data = '0;
   logic         m_ready = 1'b0;
   logic         wr_ready;
   logic         m_valid;
   logic [T-1:0] data_out;
   logic         m_last;
   logic [2:0]   vec_avail;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // model state
   logic [T-1:0] part_q[$];
   logic [T-1:0] exp_q[$];
   logic [T-1:0] got_q[$];
   logic         got_last_q[$];
   int           got_cyc_q[$];
   bit           live = 1'b0;
   bit           just_cleared = 1'b0;
   bit           model_en = 1'b0;
   bit           stall_prev = 1'b0;
   logic [T-1:0] prev_data = '0;
   logic         prev_last = 1'b0;
   bit           exp_ready;
   logic         pat [4];

   always #5 clk = ~clk;

   nn_vec_sender #(
      .N     (N),
      .T     (T),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .data_out  (data_out),
      .m_last    (m_last),
      .vec_avail (vec_avail)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Per-cycle compare against the model, then advance the model with this
   // cycle's handshakes (they take effect at the coming rising edge).
   always @(negedge clk) begin
      cyc++;
      exp_ready = model_en && ((part_q.size() + exp_q.size()) < SIZE);
      if (live) begin
         if (just_cleared) begin
            chk("clr_m_valid", 32'(m_valid), 32'd0);
            chk("clr_data_out", 32'(data_out), 32'd0);
            chk("clr_m_last", 32'(m_last), 32'd0);
         end
         chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
         chk("vec_avail", 32'(vec_avail), 32'((exp_q.size() + N - 1) / N));
         if (stall_prev) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(data_out), 32'(prev_data));
            chk("stall_last", 32'(m_last), 32'(prev_last));
         end
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               chk("early_word", 32'(m_valid), 32'd0);
            end else begin
               chk("data", 32'(data_out), 32'(exp_q[0]));
               chk("last", 32'(m_last), 32'((exp_q.size() % N) == 1));
            end
         end
      end
      if (!reset || flush) begin
         part_q.delete();
         exp_q.delete();
         live         = 1'b1;
         just_cleared = 1'b1;
         model_en     = 1'b0;
         stall_prev   = 1'b0;
      end else if (live) begin
         just_cleared = 1'b0;
         if (m_valid && m_ready && exp_q.size() > 0) begin
            $display("tx %0d data %h last %b cycle %0d", got_q.size(), data_out, m_last, cyc);
            got_q.push_back(data_out);
            got_last_q.push_back(m_last);
            got_cyc_q.push_back(cyc);
            void'(exp_q.pop_front());
         end
         if (wr_valid && exp_ready) begin
            part_q.push_back(wr_data);
            if (part_q.size() == N) begin
               foreach (part_q[i]) exp_q.push_back(part_q[i]);
               part_q.delete();
            end
         end
         stall_prev = m_valid && !m_ready;
         prev_data  = data_out;
         prev_last  = m_last;
         model_en   = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic write_word(input logic [T-1:0] w);
      int n = 0;
      wr_valid = 1'b1;
      wr_data  = w;
      @(negedge clk);
      while (!wr_ready && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!wr_ready) chk("write_timeout", 32'(wr_ready), 32'd1);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic write_seq(input int first, input int n);
      for (int i = 0; i < n; i++) write_word(16'(first + i));
   endtask

   task automatic wait_got(input int n);
      int c = 0;
      while (got_q.size() < n && c < 500) begin
         @(negedge clk);
         c++;
      end
      chk("wait_got", 32'(got_q.size()), 32'(n));
   endtask

   task automatic clear_got();
      got_q.delete();
      got_last_q.delete();
      got_cyc_q.delete();
   endtask

   task automatic check_seq(input string tag, input int first, input int n, input bit span);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_data"}, 32'(got_q[i]), 32'(16'(first + i)));
         chk({tag, "_last"}, 32'(got_last_q[i]), 32'((i % N) == (N - 1)));
      end
      if (span) chk({tag, "_span"}, 32'(got_cyc_q[n-1] - got_cyc_q[0]), 32'(n - 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      sample();
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_vec_avail", 32'(vec_avail), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      sample();
      chk("rel_wr_ready", 32'(wr_ready), 32'd1);

      // 1: single vector, latency and throughput
      tick();
      clear_got();
      m_ready = 1'b1;
      write_seq(1, N);
      sample();
      chk("t1_lat_k0", 32'(m_valid), 32'd0);
      sample();
      chk("t1_lat_k1", 32'(m_valid), 32'd0);
      sample();
      chk("t1_lat_k2", 32'(m_valid), 32'd1);
      wait_got(N);
      check_seq("t1", 1, N, 1'b1);
      repeat (3) tick();

      // 2: partial vector is held back
      clear_got();
      write_seq(11, N - 1);
      repeat (20) tick();
      sample();
      chk("t2_hold_valid", 32'(m_valid), 32'd0);
      chk("t2_hold_avail", 32'(vec_avail), 32'd0);
      tick();
      write_word(16'd18);
      wait_got(N);
      check_seq("t2", 11, N, 1'b1);
      repeat (3) tick();

      // 3: two committed vectors back to back
      clear_got();
      m_ready = 1'b0;
      write_seq(1, 2 * N);
      sample();
      chk("t3_avail", 32'(vec_avail), 32'd2);
      tick();
      m_ready = 1'b1;
      wait_got(2 * N);
      check_seq("t3", 1, 2 * N, 1'b1);
      repeat (3) tick();

      // 4: ready toggling 1,0,0,1
      clear_got();
      m_ready = 1'b0;
      write_seq(21, 2 * N);
      for (int c = 0; c < 400 && got_q.size() < 2 * N; c++) begin
         m_ready = pat[c % 4];
         tick();
      end
      m_ready = 1'b0;
      chk("t4_count", 32'(got_q.size()), 32'(2 * N));
      check_seq("t4", 21, 2 * N, 1'b0);
      repeat (3) tick();

      // 5: full buffer, slot freed after one transfer, sign preserved
      clear_got();
      for (int i = 0; i < SIZE; i++) write_word((i == 2) ? 16'(-5) : 16'(i + 1));
      sample();
      chk("t5_full_ready", 32'(wr_ready), 32'd0);
      chk("t5_full_avail", 32'(vec_avail), 32'd4);
      tick();
      wr_valid = 1'b1;
      wr_data  = 16'd99;
      repeat (3) tick();
      m_ready = 1'b1;
      sample();
      chk("t5_xfer_ready", 32'(wr_ready), 32'd0);
      tick();
      m_ready = 1'b0;
      sample();
      chk("t5_freed_ready", 32'(wr_ready), 32'd1);
      tick();
      wr_valid = 1'b0;
      m_ready  = 1'b1;
      wait_got(SIZE);
      chk("t5_neg5", 32'(got_q[2]), 32'h0000FFFB);
      chk("t5_first", 32'(got_q[0]), 32'd1);
      chk("t5_lastword", 32'(got_q[SIZE-1]), 32'(SIZE));
      repeat (10) tick();
      sample();
      chk("t5_residue_valid", 32'(m_valid), 32'd0);
      chk("t5_residue_avail", 32'(vec_avail), 32'd0);

      // 6: flush mid-vector, reset mid-write, then a clean vector
      tick();
      m_ready = 1'b0;
      flush   = 1'b1;
      tick();
      flush = 1'b0;
      clear_got();
      write_seq(40, N);
      m_ready = 1'b1;
      repeat (6) tick();
      m_ready  = 1'b0;
      flush    = 1'b1;
      m_ready  = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 16'd77;
      tick();
      flush    = 1'b0;
      wr_valid = 1'b0;
      m_ready  = 1'b0;
      sample();
      chk("t6_flush_valid", 32'(m_valid), 32'd0);
      chk("t6_flush_avail", 32'(vec_avail), 32'd0);
      tick();
      write_seq(50, 3);
      wr_valid = 1'b1;
      wr_data  = 16'd53;
      reset    = 1'b0;
      tick();
      reset    = 1'b1;
      wr_valid = 1'b0;
      sample();
      chk("t6_rst_valid", 32'(m_valid), 32'd0);
      chk("t6_rst_avail", 32'(vec_avail), 32'd0);
      chk("t6_rst_ready", 32'(wr_ready), 32'd0);
      tick();
      clear_got();
      m_ready = 1'b1;
      write_seq(100, N);
      wait_got(N);
      check_seq("t6", 100, N, 1'b1);
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
